pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage CPU pipeline (IF, ID, EX, MEM, WB) in each ring node.
- Detects load-use hazards, taken-branch redirects and data-memory/NIC wait conditions.
- Drives the hold and flush controls of the PC, IF_ID, ID_EX and EX_MEM pipeline registers.
- Keeps saturating performance counters of stall cycles and flush events.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline stall/flush controller (load-use, taken branch, MEM/NIC wait) with saturating perf counters.
// Latency: stall/flush outputs are combinational from state + inputs (same-cycle response); state and counters registered.
// Backpressure: MEM_busy holds every stage and freezes any branch flush or load stall in progress until it drops.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_rd,
    input  logic             EX_branch_taken,
    input  logic             MEM_busy,
    input  logic             cnt_clear,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_stall,
    output logic             EX_MEM_stall,
    output logic             ID_flush,
    output logic             EX_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, FLUSH} state_t;

    localparam logic [2:0]       FL_REM  = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0]       LD_REM  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    state_t           frz_q, frz_d;     // state to resume once MEM_busy drops
    state_t           eff;              // state whose behaviour applies this cycle
    logic [2:0]       rem_q, rem_d;     // remaining FLUSH / LD_STALL cycles
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             hz;
    logic             pc_s, ifid_s, idex_s, exmem_s, idf, exf, br_acc;

    // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
    assign hz = EX_mem_read && (EX_rd != 5'd0) &&
                ((ID_use_rs && (ID_rs == EX_rd)) || (ID_use_rt && (ID_rt == EX_rd)));

    // Next-state and stall/flush decode; priority MEM_busy > branch > load-use.
    always_comb begin
        state_d = state_q;
        frz_d   = frz_q;
        rem_d   = rem_q;
        pc_s    = 1'b0;
        ifid_s  = 1'b0;
        idex_s  = 1'b0;
        exmem_s = 1'b0;
        idf     = 1'b0;
        exf     = 1'b0;
        br_acc  = 1'b0;
        eff     = (state_q == MEM_WAIT) ? frz_q : state_q;
        if (MEM_busy) begin
            // EX is held, so a branch seen now is seen again once busy drops.
            pc_s    = 1'b1;
            ifid_s  = 1'b1;
            idex_s  = 1'b1;
            exmem_s = 1'b1;
            state_d = MEM_WAIT;
            frz_d   = eff;
        end else if (EX_branch_taken) begin
            idf    = 1'b1;
            exf    = 1'b1;
            br_acc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FL_REM;
            end else begin
                state_d = RUN;
                rem_d   = 3'd0;
            end
        end else begin
            case (eff)
                FLUSH: begin
                    idf = 1'b1;
                    if (rem_q <= 3'd1) begin
                        state_d = RUN;
                        rem_d   = 3'd0;
                    end else begin
                        state_d = FLUSH;
                        rem_d   = rem_q - 3'd1;
                    end
                end
                LD_STALL: begin
                    pc_s   = 1'b1;
                    ifid_s = 1'b1;
                    exf    = 1'b1;
                    if (rem_q <= 3'd1) begin
                        state_d = RUN;
                        rem_d   = 3'd0;
                    end else begin
                        state_d = LD_STALL;
                        rem_d   = rem_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (hz) begin
                        pc_s   = 1'b1;
                        ifid_s = 1'b1;
                        exf    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LD_STALL;
                            rem_d   = LD_REM;
                        end
                    end
                end
            endcase
        end
    end

    // State, freeze slot and remaining-cycle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            frz_q   <= RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            frz_q   <= frz_d;
            rem_q   <= rem_d;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (cnt_clear) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_s && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_ONE;
            if (br_acc && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_ONE;
        end
    end

    // Controls are forced low while reset is held, whatever the inputs say.
    assign PC_stall     = pc_s    & ~reset;
    assign IF_ID_stall  = ifid_s  & ~reset;
    assign ID_EX_stall  = idex_s  & ~reset;
    assign EX_MEM_stall = exmem_s & ~reset;
    assign ID_flush     = idf     & ~reset;
    assign EX_flush     = exf     & ~reset;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: directed, table-driven check of pipe_hazard_ctrl in two parameterisations.
// Latency: outputs sampled 3 time units into each cycle; counters compared before the edge.
// Backpressure: MEM_busy sequences exercise freeze/resume of flush and load stall.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, EX_rd;
    logic       ID_use_rs, ID_use_rt, EX_mem_read, EX_branch_taken, MEM_busy, cnt_clear;

    logic       pc1, ifid1, idex1, exmem1, idf1, exf1;
    logic       pc2, ifid2, idex2, exmem2, idf2, exf2;
    logic [3:0] sc1, fc1;
    logic [7:0] sc2, fc2;
    logic [5:0] o1, o2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .EX_mem_read(EX_mem_read),
        .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken), .MEM_busy(MEM_busy),
        .cnt_clear(cnt_clear), .PC_stall(pc1), .IF_ID_stall(ifid1),
        .ID_EX_stall(idex1), .EX_MEM_stall(exmem1), .ID_flush(idf1),
        .EX_flush(exf1), .stall_cycles(sc1), .flush_count(fc1));

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .LOAD_STALL_CYCLES(3), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .EX_mem_read(EX_mem_read),
        .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken), .MEM_busy(MEM_busy),
        .cnt_clear(cnt_clear), .PC_stall(pc2), .IF_ID_stall(ifid2),
        .ID_EX_stall(idex2), .EX_MEM_stall(exmem2), .ID_flush(idf2),
        .EX_flush(exf2), .stall_cycles(sc2), .flush_count(fc2));

    // {PC, IF_ID, ID_EX, EX_MEM, ID_flush, EX_flush}
    assign o1 = {pc1, ifid1, idex1, exmem1, idf1, exf1};
    assign o2 = {pc2, ifid2, idex2, exmem2, idf2, exf2};

    typedef struct packed {
        logic       busy, br, mr;
        logic [4:0] rd, rs, rt;
        logic       urs, urt, clr;
        logic [5:0] eo;
        logic [3:0] esc, efc;
    } vec_t;

    vec_t tv [28];

    function automatic vec_t mk(input logic b, br, mr, input logic [4:0] rd, rs, rt,
                                input logic urs, urt, clr, input logic [5:0] eo,
                                input logic [3:0] esc, efc);
        vec_t v;
        v.busy = b; v.br = br; v.mr = mr; v.rd = rd; v.rs = rs; v.rt = rt;
        v.urs = urs; v.urt = urt; v.clr = clr; v.eo = eo; v.esc = esc; v.efc = efc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic b, br, mr, input logic [4:0] rd, rs, rt,
                         input logic urs, urt, clr);
        MEM_busy = b; EX_branch_taken = br; EX_mem_read = mr;
        EX_rd = rd; ID_rs = rs; ID_rt = rt;
        ID_use_rs = urs; ID_use_rt = urt; cnt_clear = clr;
    endtask

    // One cycle with a canned load-use hazard (r5) when h=1; checks u1 or u2 outputs.
    task automatic one(input string nm, input int idx, input logic b, br, h, clr,
                       input bit sel2, input logic [5:0] exp);
        drive(b, br, h, h ? 5'd5 : 5'd0, h ? 5'd5 : 5'd0, 5'd0, h, 1'b0, clr);
        #3;
        chk(nm, idx, sel2 ? {26'd0, o2} : {26'd0, o1}, {26'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               b  br mr rd  rs  rt  urs urt clr eo         sc  fc
        tv[0]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 0, 0);
        tv[1]  = mk(0, 0, 1, 5,  5,  0,  1, 0, 0, 6'b110001, 0, 0);
        tv[2]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 1, 0);
        tv[3]  = mk(0, 0, 1, 0,  0,  0,  1, 0, 0, 6'b000000, 1, 0);
        tv[4]  = mk(0, 0, 1, 5,  5,  0,  0, 0, 0, 6'b000000, 1, 0);
        tv[5]  = mk(0, 0, 1, 7,  0,  7,  0, 1, 0, 6'b110001, 1, 0);
        tv[6]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 2, 0);
        tv[7]  = mk(0, 1, 0, 0,  0,  0,  0, 0, 0, 6'b000011, 2, 0);
        tv[8]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000010, 2, 1);
        tv[9]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 2, 1);
        tv[10] = mk(0, 1, 1, 5,  5,  0,  1, 0, 0, 6'b000011, 2, 1);
        tv[11] = mk(0, 0, 1, 5,  5,  0,  1, 0, 0, 6'b000010, 2, 2);
        tv[12] = mk(0, 0, 1, 5,  5,  0,  1, 0, 0, 6'b110001, 2, 2);
        tv[13] = mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 6'b111100, 3, 2);
        tv[14] = mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 6'b111100, 4, 2);
        tv[15] = mk(1, 1, 0, 0,  0,  0,  0, 0, 0, 6'b111100, 5, 2);
        tv[16] = mk(0, 1, 0, 0,  0,  0,  0, 0, 0, 6'b000011, 6, 2);
        tv[17] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000010, 6, 3);
        tv[18] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 6, 3);
        tv[19] = mk(0, 1, 0, 0,  0,  0,  0, 0, 0, 6'b000011, 6, 3);
        tv[20] = mk(1, 0, 0, 0,  0,  0,  0, 0, 0, 6'b111100, 6, 4);
        tv[21] = mk(1, 0, 0, 0,  0,  0,  0, 0, 0, 6'b111100, 7, 4);
        tv[22] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000010, 8, 4);
        tv[23] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 8, 4);
        tv[24] = mk(0, 0, 1, 5,  5,  0,  1, 0, 1, 6'b110001, 8, 4);
        tv[25] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 0, 0);
        tv[26] = mk(1, 0, 0, 0,  0,  0,  0, 0, 1, 6'b111100, 0, 0);
        tv[27] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, 6'b000000, 0, 0);

        // Outputs stay low during reset even with MEM_busy high.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #3;
        chk("rst_outs", 0, {26'd0, o1}, 32'd0);
        chk("rst_cnt", 0, {24'd0, sc1, fc1}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 28; i++) begin
            drive(tv[i].busy, tv[i].br, tv[i].mr, tv[i].rd, tv[i].rs, tv[i].rt,
                  tv[i].urs, tv[i].urt, tv[i].clr);
            #3;
            chk("vec_out", i, {26'd0, o1}, {26'd0, tv[i].eo});
            chk("vec_sc", i, {28'd0, sc1}, {28'd0, tv[i].esc});
            chk("vec_fc", i, {28'd0, fc1}, {28'd0, tv[i].efc});
            @(posedge clk); #1;
        end

        // Saturation: 20 busy cycles on a 4-bit counter stop at 15.
        do_reset();
        for (int i = 0; i < 20; i++) one("sat_busy", i, 1, 0, 0, 0, 0, 6'b111100);
        chk("sat_sc", 0, {28'd0, sc1}, 32'd15);
        one("sat_clr", 0, 1, 0, 0, 1, 0, 6'b111100);
        chk("sat_sc_clr", 0, {28'd0, sc1}, 32'd0);

        // Async reset in the middle of FLUSH.
        do_reset();
        one("rf_br", 0, 0, 1, 0, 0, 0, 6'b000011);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rf_flush", 0, {26'd0, o1}, 32'b000010);
        reset = 1'b1;
        #1;
        chk("rf_during", 0, {26'd0, o1}, 32'd0);
        chk("rf_fc", 0, {28'd0, fc1}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rf_after", 0, {26'd0, o1}, 32'd0);
        @(posedge clk); #1;
        one("rf_next", 0, 0, 0, 0, 0, 0, 6'b000000);

        // Async reset in the middle of MEM_WAIT.
        one("rm_busy", 0, 1, 0, 0, 0, 0, 6'b111100);
        one("rm_busy", 1, 1, 0, 0, 0, 0, 6'b111100);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("rm_during", 0, {26'd0, o1}, 32'd0);
        chk("rm_sc", 0, {28'd0, sc1}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rm_after", 0, {26'd0, o1}, 32'd0);
        @(posedge clk); #1;
        one("rm_next", 0, 0, 0, 0, 0, 0, 6'b000000);

        // u2: three-cycle load stall, freeze under busy, branch cancel, single-cycle flush.
        do_reset();
        one("u2_ld", 0, 0, 0, 1, 0, 1, 6'b110001);
        one("u2_ld", 1, 0, 0, 0, 0, 1, 6'b110001);
        one("u2_ld", 2, 0, 0, 0, 0, 1, 6'b110001);
        one("u2_ld", 3, 0, 0, 0, 0, 1, 6'b000000);
        one("u2_frz", 0, 0, 0, 1, 0, 1, 6'b110001);
        one("u2_frz", 1, 0, 0, 0, 0, 1, 6'b110001);
        one("u2_frz", 2, 1, 0, 0, 0, 1, 6'b111100);
        one("u2_frz", 3, 0, 0, 0, 0, 1, 6'b110001);
        one("u2_frz", 4, 0, 0, 0, 0, 1, 6'b000000);
        one("u2_cancel", 0, 0, 0, 1, 0, 1, 6'b110001);
        one("u2_cancel", 1, 0, 1, 0, 0, 1, 6'b000011);
        one("u2_cancel", 2, 0, 0, 0, 0, 1, 6'b000000);
        one("u2_br", 0, 0, 1, 0, 0, 1, 6'b000011);
        one("u2_br", 1, 0, 0, 0, 0, 1, 6'b000000);
        chk("u2_sc", 0, {24'd0, sc2}, 32'd8);
        chk("u2_fc", 0, {24'd0, fc2}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
